// File: rtl/device_event_arbiter.sv
// Round-robin arbiter that serialises join/leave events from NREQ requesters onto a single
// monitor strobe, keeping a shadow active-device count that saturates by rejecting events.
module device_event_arbiter #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned MAX_DEV = 200
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic [NREQ-1:0] req,
   input  logic [NREQ-1:0] dir,
   output logic [NREQ-1:0] ack,
   output logic [NREQ-1:0] nack,
   output logic            change,
   output logic            on_off,
   output logic [7:0]      dev_count,
   output logic            busy
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {StIdle, StIssue, StWaitRel} state_e;

   state_e            state_q;
   logic [PW-1:0]     rr_ptr_q;
   logic [PW-1:0]     win_q;
   logic              dir_q;
   logic [NREQ-1:0]   ack_q;
   logic [NREQ-1:0]   nack_q;
   logic              change_q;
   logic              on_off_q;
   logic [7:0]        dev_count_q;
   logic              busy_q;

   logic [2*NREQ-1:0] req_rot;
   logic              win_found;
   logic [PW-1:0]     win_idx;
   logic [PW-1:0]     rr_next;
   logic              legal;
   int unsigned       sum;

   // Rotate requests so bit 0 is rr_ptr, then take the lowest set bit.
   always_comb begin
      req_rot   = {req, req} >> rr_ptr_q;
      win_found = 1'b0;
      win_idx   = '0;
      sum       = 0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!win_found && req_rot[i]) begin
            win_found = 1'b1;
            sum       = 32'(rr_ptr_q) + i;
            if (sum >= NREQ) begin
               sum = sum - NREQ;
            end
            win_idx = PW'(sum);
         end
      end
      rr_next = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
   end

   assign legal = dir_q ? (dev_count_q < 8'(MAX_DEV)) : (dev_count_q != 8'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         rr_ptr_q    <= '0;
         win_q       <= '0;
         dir_q       <= 1'b0;
         ack_q       <= '0;
         nack_q      <= '0;
         change_q    <= 1'b0;
         on_off_q    <= 1'b0;
         dev_count_q <= 8'd0;
         busy_q      <= 1'b0;
      end else begin
         ack_q    <= '0;
         nack_q   <= '0;
         change_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (en && win_found) begin
                  win_q    <= win_idx;
                  dir_q    <= dir[win_idx];
                  rr_ptr_q <= rr_next;
                  state_q  <= StIssue;
                  busy_q   <= 1'b1;
               end
            end
            StIssue: begin
               // Out-of-range events are rejected so the count never wraps.
               if (legal) begin
                  change_q     <= 1'b1;
                  on_off_q     <= dir_q;
                  ack_q[win_q] <= 1'b1;
                  dev_count_q  <= dir_q ? dev_count_q + 8'd1 : dev_count_q - 8'd1;
               end else begin
                  nack_q[win_q] <= 1'b1;
               end
               state_q <= StWaitRel;
            end
            StWaitRel: begin
               if (!req[win_q]) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ack       = ack_q;
   assign nack      = nack_q;
   assign change    = change_q;
   assign on_off    = on_off_q;
   assign dev_count = dev_count_q;
   assign busy      = busy_q;

endmodule
